// File: rtl/mpadd_pkg.sv
// Shared definitions for the word-serial multi-precision adder.
package mpadd_pkg;

    // Width of one datapath word handled by the shared adder per cycle.
    localparam int WORD_W = 32;

    // Sequencer states: waiting for a request, walking the words, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Carry out of the top bit of a word, rebuilt from the operand MSBs and the sum MSB.
    // A carry leaves bit 31 when both MSBs are set, or when exactly one is set and the
    // sum bit came out 0 (the incoming carry completed the pair).
    function automatic logic word_carry(input logic a_msb, input logic b_msb, input logic s_msb);
        word_carry = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
    endfunction

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        signed_ovf = (a_msb == b_msb) & (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mpadd_seq_cla.sv
// 32-bit carry-lookahead adder used as the single shared word adder.
// Only the sum is exposed; callers reconstruct the carry-out themselves.
module cla
    import mpadd_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o
);

    localparam int GRP_W = 4;
    localparam int N_GRP = WORD_W / GRP_W;

    // Two-level lookahead: 4-bit group generate/propagate, then group carries,
    // then bit carries expanded inside each group.
    function automatic logic [WORD_W-1:0] cla_calc(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic              cin
    );
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] p;
        logic [WORD_W-1:0] c;
        logic [N_GRP-1:0]  gg;
        logic [N_GRP-1:0]  pg;
        logic [N_GRP:0]    cg;
        g  = a & b;
        p  = a ^ b;
        c  = {WORD_W{1'b0}};
        gg = {N_GRP{1'b0}};
        pg = {N_GRP{1'b0}};
        cg = {(N_GRP+1){1'b0}};
        for (int j = 0; j < N_GRP; j++) begin
            gg[j] = g[j*GRP_W+3]
                  | (p[j*GRP_W+3] & g[j*GRP_W+2])
                  | (p[j*GRP_W+3] & p[j*GRP_W+2] & g[j*GRP_W+1])
                  | (p[j*GRP_W+3] & p[j*GRP_W+2] & p[j*GRP_W+1] & g[j*GRP_W]);
            pg[j] = p[j*GRP_W+3] & p[j*GRP_W+2] & p[j*GRP_W+1] & p[j*GRP_W];
        end
        cg[0] = cin;
        for (int j = 0; j < N_GRP; j++) begin
            cg[j+1] = gg[j] | (pg[j] & cg[j]);
        end
        for (int j = 0; j < N_GRP; j++) begin
            c[j*GRP_W]   = cg[j];
            c[j*GRP_W+1] = g[j*GRP_W] | (p[j*GRP_W] & cg[j]);
            c[j*GRP_W+2] = g[j*GRP_W+1] | (p[j*GRP_W+1] & g[j*GRP_W])
                         | (p[j*GRP_W+1] & p[j*GRP_W] & cg[j]);
            c[j*GRP_W+3] = g[j*GRP_W+2] | (p[j*GRP_W+2] & g[j*GRP_W+1])
                         | (p[j*GRP_W+2] & p[j*GRP_W+1] & g[j*GRP_W])
                         | (p[j*GRP_W+2] & p[j*GRP_W+1] & p[j*GRP_W] & cg[j]);
        end
        cla_calc = p ^ c;
    endfunction

    // Pure combinational word sum.
    always_comb begin
        sum_o = cla_calc(a_i, b_i, cin_i);
    end

endmodule

// File: rtl/mpadd_seq.sv
// Word-serial multi-precision adder/subtractor. One 32-bit word per cycle goes
// through a single shared CLA; the carry is kept in a register between words.
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] in_a,
    input  logic [WORD_W*NWORDS-1:0] in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf
);

    localparam int W  = WORD_W * NWORDS;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] word_a_s;
    logic [WORD_W-1:0] word_b_s;
    logic              word_cin_s;
    logic [WORD_W-1:0] word_sum_s;
    logic              word_cout_s;

    // Select the current word of both operands and its incoming carry.
    // At word 0 the carry register holds the captured subtract flag, so the
    // registered flag is used directly there; both carry the same value.
    always_comb begin
        word_a_s = a_q[k_q*WORD_W +: WORD_W];
        word_b_s = b_q[k_q*WORD_W +: WORD_W];
        if (k_q == K_ZERO) begin
            word_cin_s = sub_q;
        end else begin
            word_cin_s = carry_q;
        end
    end

    cla u_cla (
        .a_i   (word_a_s),
        .b_i   (word_b_s),
        .cin_i (word_cin_s),
        .sum_o (word_sum_s)
    );

    // Word carry-out rebuilt from MSBs, since the adder exposes only the sum.
    always_comb begin
        word_cout_s = word_carry(word_a_s[WORD_W-1], word_b_s[WORD_W-1], word_sum_s[WORD_W-1]);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    if (in_sub) begin
                        b_d = ~in_b;
                    end else begin
                        b_d = in_b;
                    end
                    sub_d   = in_sub;
                    k_d     = K_ZERO;
                    carry_d = in_sub;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[k_q*WORD_W +: WORD_W] = word_sum_s;
                carry_d = word_cout_s;
                if (k_q == K_LAST) begin
                    // Top word: its MSBs are the operand/result sign bits.
                    cout_d  = word_cout_s;
                    ovf_d   = signed_ovf(word_a_s[WORD_W-1], word_b_s[WORD_W-1],
                                         word_sum_s[WORD_W-1]);
                    k_d     = K_ZERO;
                    state_d = DONE;
                end else begin
                    k_d     = k_q + K_ONE;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = K_ZERO;
                carry_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= K_ZERO;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq (NWORDS=4): carry chaining, overflow, back-pressure,
// mid-operation reset and a short reference-model sequence.
module tb_mpadd_seq;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks;
    int n_errors;

    mpadd_seq #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for out_valid; called at the negedge right after the accepting edge.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, lat, NW);
    endtask

    // Consume the presented result after 'hold' stalled cycles.
    task automatic consume(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, out_valid, 0);
        check_val({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] exp_sum,
                         input logic exp_c, input logic exp_v, input int hold);
        @(negedge clk);
        check_val({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(tag);
        check_val({tag, "_sum"}, out_sum, exp_sum);
        check_val({tag, "_cout"}, out_cout, exp_c);
        check_val({tag, "_ovf"}, out_ovf, exp_v);
        consume(tag, hold);
    endtask

    logic [W-1:0] ones_v;
    logic [W-1:0] held_sum;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rbb;
    logic [W:0]   full;
    logic         rsub;
    int           rises;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = {W{1'b0}};
        in_b      = {W{1'b0}};
        in_sub    = 1'b0;
        out_ready = 1'b0;
        ones_v    = {W{1'b1}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_sum", out_sum, 0);
        check_val("rst_cout", out_cout, 0);
        check_val("rst_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);

        // Carry across the word 0 -> word 1 boundary.
        do_op("add_w0carry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0,
              128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0, 0);
        // Carry ripples through every word and out.
        do_op("add_allones", ones_v, 128'h1, 1'b0, 128'h0, 1'b1, 1'b0, 1);
        // Positive overflow.
        do_op("add_ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
              128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, 0);
        // 5 - 7 borrows.
        do_op("sub_borrow", 128'h5, 128'h7, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 2);
        // 7 - 5 no borrow.
        do_op("sub_noborrow", 128'h7, 128'h5, 1'b1, 128'h2, 1'b1, 1'b0, 0);
        // Most negative minus one overflows.
        do_op("sub_ovf", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1, 1'b1,
              128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);

        // Back-pressure: in_valid stays high with changing operands throughout.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
        in_b     = 128'h0000_0010_0000_0020_0000_0030_0000_0040;
        in_sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 128'hAAAA_0000_0000_0000_0000_0000_0000_0001;
        in_b = 128'h1111_0000_0000_0000_0000_0000_0000_0002;
        wait_result("bp_first");
        check_val("bp_first_sum", out_sum, 128'h0000_0011_0000_0022_0000_0033_0000_0044);
        held_sum = 128'h0000_0011_0000_0022_0000_0033_0000_0044;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            in_a = in_a + 128'h1;
            check_val("bp_hold_valid", out_valid, 1);
            check_val("bp_hold_ready", in_ready, 0);
            check_val("bp_hold_sum", out_sum, held_sum);
        end
        in_a = 128'hAAAA_0000_0000_0000_0000_0000_0000_0001;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_consumed", out_valid, 0);
        check_val("bp_idle_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("bp_second_accepted", in_ready, 0);
        wait_result("bp_second");
        check_val("bp_second_sum", out_sum, 128'hBBBB_0000_0000_0000_0000_0000_0000_0003);
        check_val("bp_second_cout", out_cout, 0);
        consume("bp_second", 0);

        // Reset in the middle of RUN at word index 2.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
        in_b     = 128'h0101_0101_0202_0202_0303_0303_0404_0404;
        in_sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_valid", out_valid, 0);
        check_val("abort_sum", out_sum, 0);
        check_val("abort_cout", out_cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_in_ready", in_ready, 1);
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) rises++;
        end
        check_val("abort_no_result", rises, 0);
        do_op("after_abort", 128'h1111_1111_2222_2222_3333_3333_4444_4444,
              128'h0101_0101_0202_0202_0303_0303_0404_0404, 1'b0,
              128'h1212_1212_2424_2424_3636_3636_4848_4848, 1'b0, 1'b0, 0);

        // Reference-model sequence with random operands and stall lengths.
        for (int n = 0; n < 10; n++) begin
            ra   = {$urandom, $urandom, $urandom, $urandom};
            rb   = {$urandom, $urandom, $urandom, $urandom};
            rsub = 1'($urandom_range(0, 1));
            rbb  = rsub ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, rbb} + {{W{1'b0}}, rsub};
            do_op("rand", ra, rb, rsub, full[W-1:0], full[W],
                  (ra[W-1] == rbb[W-1]) && (full[W-1] != ra[W-1]),
                  int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
